// File: rtl/sh_multicycle_core.sv
// Multicycle SH-style core: FETCH/EXEC/MEM/HALT sequencer with 16-bit instruction words.
// Define SH_CORE_MUL_EN to add MUL.L / STS MACL and the MACL register.
module sh_multicycle_core #(
  parameter int unsigned           REG_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  stall,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [15:0]           imem_rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [REG_WIDTH-1:0]  dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [REG_WIDTH-1:0]  dmem_rdata,
  output logic                  retire,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  illegal,
  output logic                  halted
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;
  typedef enum logic [3:0] {
    OP_NOP, OP_MOVI, OP_ADD, OP_ADDI, OP_CMP, OP_LD, OP_ST, OP_BRA,
    OP_BT, OP_BSR, OP_RTS, OP_SLEEP, OP_MUL, OP_STS, OP_ILL
  } op_t;

  state_t                state, state_n;
  op_t                   op;
  logic [ADDR_WIDTH-1:0] pc, pc_n, pc2, pc4, bra_t, bt_t;
  logic [REG_WIDTH-1:0]  regs [16];
  logic [REG_WIDTH-1:0]  pr, pr_n, rn_v, rm_v, imm_s, mem_addr_full;
  logic                  t, t_n;
  logic [15:0]           ir, ir_n;
  logic                  rf_we;
  logic [3:0]            rf_idx;
  logic [REG_WIDTH-1:0]  rf_data;
`ifdef SH_CORE_MUL_EN
  logic [REG_WIDTH-1:0]  macl, macl_n;
`endif

  assign rn_v  = regs[ir[11:8]];
  assign rm_v  = regs[ir[7:4]];
  assign imm_s = {{(REG_WIDTH-8){ir[7]}}, ir[7:0]};
  assign pc2   = pc + ADDR_WIDTH'(2);
  assign pc4   = pc + ADDR_WIDTH'(4);
  assign bra_t = pc4 + {{(ADDR_WIDTH-13){ir[11]}}, ir[11:0], 1'b0};
  assign bt_t  = pc4 + {{(ADDR_WIDTH-9){ir[7]}}, ir[7:0], 1'b0};

  always_comb begin
    op = OP_ILL;
    casez (ir)
      16'h0009:              op = OP_NOP;
      16'h000B:              op = OP_RTS;
      16'h001B:              op = OP_SLEEP;
      16'b1110_????_????_????: op = OP_MOVI;
      16'b0011_????_????_1100: op = OP_ADD;
      16'b0011_????_????_0000: op = OP_CMP;
      16'b0111_????_????_????: op = OP_ADDI;
      16'b0110_????_????_0010: op = OP_LD;
      16'b0010_????_????_0010: op = OP_ST;
      16'b1010_????_????_????: op = OP_BRA;
      16'b1011_????_????_????: op = OP_BSR;
      16'b1000_1001_????_????: op = OP_BT;
`ifdef SH_CORE_MUL_EN
      16'b0000_????_????_0111: op = OP_MUL;
      16'b0000_????_0001_1010: op = OP_STS;
`endif
      default:               op = OP_ILL;
    endcase
  end

  // Every update is gated by stall here, so the register process needs no enable.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    pr_n    = pr;
    t_n     = t;
`ifdef SH_CORE_MUL_EN
    macl_n  = macl;
`endif
    rf_we   = 1'b0;
    rf_idx  = ir[11:8];
    rf_data = rn_v;
    retire  = 1'b0;
    illegal = 1'b0;
    if (!stall) begin
      unique case (state)
        FETCH: if (imem_ack) begin
          ir_n    = imem_rdata;
          state_n = EXEC;
        end
        EXEC: begin
          state_n = FETCH;
          pc_n    = pc2;
          retire  = 1'b1;
          case (op)
            OP_MOVI: begin rf_we = 1'b1; rf_data = imm_s; end
            OP_ADD:  begin rf_we = 1'b1; rf_data = rn_v + rm_v; end
            OP_ADDI: begin rf_we = 1'b1; rf_data = rn_v + imm_s; end
            OP_CMP:  t_n = (rn_v == rm_v);
            OP_LD, OP_ST: begin state_n = MEM; pc_n = pc; retire = 1'b0; end
            OP_BRA:  pc_n = bra_t;
            OP_BT:   if (t) pc_n = bt_t;
            OP_BSR:  begin pr_n = REG_WIDTH'(pc4); pc_n = bra_t; end
            OP_RTS:  pc_n = pr[ADDR_WIDTH-1:0];
            OP_SLEEP: begin state_n = HALT; pc_n = pc; end
`ifdef SH_CORE_MUL_EN
            OP_MUL:  macl_n = rn_v * rm_v;
            OP_STS:  begin rf_we = 1'b1; rf_data = macl; end
`endif
            OP_ILL:  illegal = 1'b1;
            default: ;
          endcase
        end
        MEM: if (dmem_ack) begin
          state_n = FETCH;
          pc_n    = pc2;
          retire  = 1'b1;
          if (op == OP_LD) begin
            rf_we   = 1'b1;
            rf_data = dmem_rdata;
          end
        end
        HALT: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= FETCH;
      pc    <= {RESET_PC[ADDR_WIDTH-1:1], 1'b0};
      ir    <= 16'h0009;
      pr    <= '0;
      t     <= 1'b0;
`ifdef SH_CORE_MUL_EN
      macl  <= '0;
`endif
      for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      state <= state_n;
      pc    <= {pc_n[ADDR_WIDTH-1:1], 1'b0};
      ir    <= ir_n;
      pr    <= pr_n;
      t     <= t_n;
`ifdef SH_CORE_MUL_EN
      macl  <= macl_n;
`endif
      if (rf_we) regs[rf_idx] <= rf_data;
    end
  end

  // Request lines decode straight from state, so an asynchronous reset drops them at once.
  assign mem_addr_full = (op == OP_ST) ? rn_v : rm_v;
  assign imem_req      = n_reset && (state == FETCH);
  assign imem_addr     = pc;
  assign dmem_req      = (state == MEM);
  assign dmem_we       = (state == MEM) && (op == OP_ST);
  assign dmem_addr     = (state == MEM) ? mem_addr_full[ADDR_WIDTH-1:0] : '0;
  assign dmem_wdata    = ((state == MEM) && (op == OP_ST)) ? rm_v : '0;
  assign pc_o          = retire ? pc : '0;
  assign halted        = (state == HALT);

endmodule

// File: tb/tb_sh_multicycle_core.sv
// Directed bench for sh_multicycle_core with an instruction-level reference model.
module tb_sh_multicycle_core;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        stall = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic        retire, illegal, halted;
  logic [31:0] pc_o;

  sh_multicycle_core #(.REG_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .n_reset(n_reset), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .retire(retire), .pc_o(pc_o), .illegal(illegal), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memories
  logic [15:0] imem [256];
  logic [31:0] dmem [512];
  int ddelay = 0;
  int dcnt = 0;

  always @(negedge clk) begin
    imem_ack   = imem_req;
    imem_rdata = imem[imem_addr[8:1]];
    if (dmem_req) begin
      dmem_ack   = (dcnt >= ddelay);
      dcnt++;
      dmem_rdata = dmem[dmem_addr[10:2]];
    end else begin
      dmem_ack = 1'b0;
      dcnt     = 0;
    end
  end

  // Instruction-level reference model
  typedef enum {K_NOP, K_MOVI, K_ADD, K_ADDI, K_CMP, K_LD, K_ST, K_BRA, K_BT, K_BSR,
                K_RTS, K_SLEEP, K_MUL, K_STS, K_ILL} kind_t;

  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_pr, m_macl;
  logic        m_t, m_halt;

  function automatic kind_t kind_of(input logic [15:0] w);
    if (w == 16'h0009) return K_NOP;
    if (w == 16'h000B) return K_RTS;
    if (w == 16'h001B) return K_SLEEP;
    if (w[15:12] == 4'hE) return K_MOVI;
    if (w[15:12] == 4'h3 && w[3:0] == 4'hC) return K_ADD;
    if (w[15:12] == 4'h3 && w[3:0] == 4'h0) return K_CMP;
    if (w[15:12] == 4'h7) return K_ADDI;
    if (w[15:12] == 4'h6 && w[3:0] == 4'h2) return K_LD;
    if (w[15:12] == 4'h2 && w[3:0] == 4'h2) return K_ST;
    if (w[15:12] == 4'hA) return K_BRA;
    if (w[15:12] == 4'hB) return K_BSR;
    if (w[15:8] == 8'h89) return K_BT;
`ifdef SH_CORE_MUL_EN
    if (w[15:12] == 4'h0 && w[3:0] == 4'h7) return K_MUL;
    if (w[15:12] == 4'h0 && w[7:0] == 8'h1A) return K_STS;
`endif
    return K_ILL;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_pc = '0; m_pr = '0; m_macl = '0; m_t = 1'b0; m_halt = 1'b0;
  endtask

  task automatic model_step(input logic [15:0] w);
    logic [3:0]  n, m;
    logic [31:0] nxt;
    n = w[11:8];
    m = w[7:4];
    nxt = m_pc + 32'd2;
    case (kind_of(w))
      K_MOVI:  m_r[n] = {{24{w[7]}}, w[7:0]};
      K_ADD:   m_r[n] = m_r[n] + m_r[m];
      K_ADDI:  m_r[n] = m_r[n] + {{24{w[7]}}, w[7:0]};
      K_CMP:   m_t = (m_r[n] == m_r[m]);
      K_LD:    m_r[n] = dmem[m_r[m][10:2]];
      K_ST:    dmem[m_r[n][10:2]] = m_r[m];
      K_BRA:   nxt = m_pc + 32'd4 + {{19{w[11]}}, w[11:0], 1'b0};
      K_BSR:   begin m_pr = m_pc + 32'd4; nxt = m_pc + 32'd4 + {{19{w[11]}}, w[11:0], 1'b0}; end
      K_BT:    if (m_t) nxt = m_pc + 32'd4 + {{23{w[7]}}, w[7:0], 1'b0};
      K_RTS:   nxt = m_pr;
      K_SLEEP: begin m_halt = 1'b1; nxt = m_pc; end
      K_MUL:   m_macl = m_r[n] * m_r[m];
      K_STS:   m_r[n] = m_macl;
      default: ;
    endcase
    m_pc = nxt & 32'hFFFF_FFFE;
  endtask

  // Per-cycle comparison against the model
  logic        chk_en = 1'b0;
  logic [15:0] cw;
  kind_t       ck;
  int          retire_cnt = 0;
  int          ill_cnt = 0;
  int          st100_cnt = 0;
  logic [31:0] pcq [$];
  logic [31:0] stq [$];

  always @(negedge clk) begin
    #1;
    if (n_reset && chk_en) begin
      cw = imem[m_pc[8:1]];
      ck = kind_of(cw);
      if (imem_req) chk("fetch_addr", imem_addr, m_pc);
      if (dmem_req) begin
        if (ck == K_LD) begin
          chk("ld_addr", dmem_addr, m_r[cw[7:4]]);
          chk("ld_we", {31'b0, dmem_we}, 32'd0);
        end else if (ck == K_ST) begin
          chk("st_addr", dmem_addr, m_r[cw[11:8]]);
          chk("st_we", {31'b0, dmem_we}, 32'd1);
          chk("st_wdata", dmem_wdata, m_r[cw[7:4]]);
        end else begin
          chk("dmem_spurious", {31'b0, dmem_req}, 32'd0);
        end
        if (dmem_addr == 32'h100) st100_cnt++;
      end
      chk("halted", {31'b0, halted}, {31'b0, m_halt});
      if (!retire) chk("illegal_idle", {31'b0, illegal}, 32'd0);
      if (retire) begin
        chk("retire_pc", pc_o, m_pc);
        chk("illegal_flag", {31'b0, illegal}, {31'b0, (ck == K_ILL)});
        if (illegal) ill_cnt++;
        if (ck == K_ST) stq.push_back(dmem_wdata);
        pcq.push_back(m_pc);
        retire_cnt++;
        model_step(cw);
      end
    end
  end

  function automatic logic [31:0] pc_after(input logic [31:0] a);
    for (int i = 0; i + 1 < pcq.size(); i++)
      if (pcq[i] == a) return pcq[i+1];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0009;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 n_reset = 1'b0;
  endtask

  task automatic start_run();
    model_reset();
    pcq.delete();
    stq.delete();
    retire_cnt = 0; ill_cnt = 0; st100_cnt = 0;
    chk_en = 1'b1;
    @(posedge clk);
    #2 n_reset = 1'b1;
  endtask

  task automatic wait_halt(input int budget, input string nm);
    int i;
    i = 0;
    while (!halted && i < budget) begin
      @(negedge clk);
      i++;
    end
    #2 chk(nm, {31'b0, halted}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int i;
    clear_imem();
    for (int k = 0; k < 512; k++) dmem[k] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_dmem_we", {31'b0, dmem_we}, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'h0);
    chk("rst_dmem_wdata", dmem_wdata, 32'h0);
    chk("rst_retire", {31'b0, retire}, 32'd0);
    chk("rst_pc_o", pc_o, 32'h0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);

    // Zero-wait arithmetic sequence, SLEEP reached after 8 cycles
    imem[0] = 16'hE105; imem[1] = 16'hE2FD; imem[2] = 16'h312C; imem[3] = 16'h001B;
    start_run();
    repeat (7) @(posedge clk);
    #2 chk("t1_halt_c7", {31'b0, halted}, 32'd0);
    @(posedge clk);
    #2 chk("t1_halt_c8", {31'b0, halted}, 32'd1);
    chk("t1_retires", retire_cnt, 32'd4);
    chk("t1_last_pc", pcq[pcq.size()-1], 32'h6);
    chk("t1_model_r1", m_r[1], 32'd2);

    // Branches, loads, slow store, BSR/RTS, MUL/STS, stall during fetch
    do_reset();
    clear_imem();
    imem[8'h00] = 16'hE105; imem[8'h01] = 16'hE2FD; imem[8'h02] = 16'h312C; imem[8'h03] = 16'hE340;
    imem[8'h04] = 16'h2312; imem[8'h05] = 16'h0009; imem[8'h06] = 16'hFFFF; imem[8'h07] = 16'h3110;
    imem[8'h08] = 16'h8904;
    for (int k = 8'h09; k <= 8'h0D; k++) imem[k] = 16'hE7AA;
    imem[8'h0E] = 16'h333C; imem[8'h0F] = 16'h6132; imem[8'h10] = 16'h333C; imem[8'h11] = 16'h2312;
    imem[8'h12] = 16'hB00C; imem[8'h13] = 16'hE7AA; imem[8'h14] = 16'h3120; imem[8'h15] = 16'h8904;
    imem[8'h16] = 16'hE107; imem[8'h17] = 16'hE206; imem[8'h18] = 16'h0127; imem[8'h19] = 16'h031A;
    imem[8'h1A] = 16'hE550; imem[8'h1B] = 16'h2532; imem[8'h1C] = 16'h001B;
    imem[8'h20] = 16'h7601; imem[8'h21] = 16'h000B;
    dmem[32'h80 >> 2] = 32'hDEAD_BEEF;
    ddelay = 3;
    start_run();
    i = 0;
    do begin
      @(negedge clk);
      #2 i++;
    end while (!(imem_req && imem_addr == 32'h0A) && i < 200);
    chk("stall_reach", imem_addr, 32'h0A);
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #2;
      chk("stall_req", {31'b0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, 32'h0A);
      chk("stall_retire", {31'b0, retire}, 32'd0);
    end
    stall = 1'b0;
    wait_halt(400, "p2_halt");
    chk("p2_store_r1", dmem[32'h40 >> 2], 32'd2);
    chk("p2_store_beef", dmem[32'h100 >> 2], 32'hDEAD_BEEF);
    chk("p2_store_req_cycles", st100_cnt, 32'd4);
    chk("p2_bt_taken", pc_after(32'h10), 32'h1C);
    chk("p2_bt_not_taken", pc_after(32'h2A), 32'h2C);
    chk("p2_bsr", pc_after(32'h24), 32'h40);
    chk("p2_rts", pc_after(32'h42), 32'h28);
`ifdef SH_CORE_MUL_EN
    chk("p2_mul_result", dmem[32'h50 >> 2], 32'd42);
    chk("p2_illegal_cnt", ill_cnt, 32'd1);
`else
    chk("p2_mul_result", dmem[32'h50 >> 2], 32'h100);
    chk("p2_illegal_cnt", ill_cnt, 32'd3);
`endif

    // Reset during a load in MEM
    do_reset();
    clear_imem();
    imem[0] = 16'hE340; imem[1] = 16'hE560; imem[2] = 16'h2542;
    imem[3] = 16'h6432; imem[4] = 16'h2542; imem[5] = 16'h001B;
    for (int k = 0; k < 512; k++) dmem[k] = '0;
    dmem[32'h40 >> 2] = 32'h0000_1234;
    dmem[32'h60 >> 2] = 32'h5555_5555;
    ddelay = 30;
    start_run();
    i = 0;
    do begin
      @(negedge clk);
      #2 i++;
    end while (!(dmem_req && dmem_addr == 32'h40) && i < 300);
    chk("p3_load_reach", dmem_addr, 32'h40);
    chk("p3_first_store", dmem[32'h60 >> 2], 32'h0);
    repeat (2) @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    chk("p3_rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("p3_rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("p3_rst_retire", {31'b0, retire}, 32'd0);
    dmem[32'h60 >> 2] = 32'hFFFF_FFFF;
    ddelay = 0;
    start_run();
    @(negedge clk);
    #2;
    chk("p3_restart_req", {31'b0, imem_req}, 32'd1);
    chk("p3_restart_addr", imem_addr, 32'h0);
    wait_halt(200, "p3_halt");
    chk("p3_store_count", stq.size(), 32'd2);
    if (stq.size() >= 2) begin
      chk("p3_r4_untouched", stq[0], 32'h0);
      chk("p3_r4_loaded", stq[1], 32'h1234);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sh_multicycle_core.md
SH_MULTICYCLE_CORE -- requirements
Module: sh_multicycle_core

Interface
REQ-001 SHALL have parameters: REG_WIDTH, default 32, datapath/register width (>=16); ADDR_WIDTH, default 32, memory address width (<=REG_WIDTH); RESET_PC, default 0, first fetch address.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 n_reset  in  1  asynchronous, active-low reset.
REQ-004 stall  in  1  freezes state, PC and all request outputs while high.
REQ-005 imem_req / imem_addr / imem_ack / imem_rdata  out 1 / out ADDR_WIDTH / in 1 / in 16  instruction fetch channel.
REQ-006 dmem_req / dmem_we / dmem_addr / dmem_wdata  out 1 / out 1 / out ADDR_WIDTH / out REG_WIDTH  data request; dmem_ack / dmem_rdata  in 1 / in REG_WIDTH  data response.
REQ-007 retire  out 1  one-cycle pulse per completed instruction; pc_o  out ADDR_WIDTH  PC of that instruction.
REQ-008 illegal  out 1  one-cycle pulse on undecodable opcode; halted  out 1  high in HALT state.

Function
REQ-009 Internal state: R0-R15 (REG_WIDTH each), PC, PR, MACL, T flag, 16-bit IR.
REQ-010 FSM states FETCH, EXEC, MEM, HALT; FETCH->EXEC on imem_ack; EXEC->MEM for loads/stores, EXEC->HALT for SLEEP, else EXEC->FETCH; MEM->FETCH on dmem_ack.
REQ-011 Handshake: req asserted with stable addr/we/wdata until ack sampled high at a rising edge; req low the cycle after ack; ack without req ignored.
REQ-012 Ack may arrive in the first req cycle; minimum latency 2 cycles per non-memory instruction, 3 per load/store.
REQ-013 stall high: no state, PC, register or output-register update; pending req held; ack sampled during stall is ignored (requester keeps req high).
REQ-014 NOP 0x0009: PC+=2.
REQ-015 MOV #imm,Rn (1110nnnniiiiiiii): Rn=sext(imm8).
REQ-016 ADD Rm,Rn (0011nnnnmmmm1100): Rn=Rn+Rm modulo 2^REG_WIDTH, no flag change.
REQ-017 ADD #imm,Rn (0111nnnniiiiiiii): Rn=Rn+sext(imm8).
REQ-018 CMP/EQ Rm,Rn (0011nnnnmmmm0000): T=(Rn==Rm).
REQ-019 MOV.L @Rm,Rn (0110nnnnmmmm0010): dmem_addr=Rm[ADDR_WIDTH-1:0], we=0, Rn=dmem_rdata at ack; MOV.L Rm,@Rn (0010nnnnmmmm0010): addr=Rn, we=1, wdata=Rm.
REQ-020 BRA (1010 d12): PC=PC+4+(sext(d12)<<1); BT (10001001 d8): if T, PC=PC+4+(sext(d8)<<1), else PC+=2; no delay slot executed.
REQ-021 BSR (1011 d12): PR=PC+4, then as BRA; RTS 0x000B: PC=PR.
REQ-022 SLEEP 0x001B: retire, enter HALT; HALT exits only on reset.
REQ-023 Any other opcode: illegal pulse, executed as NOP, retire asserted.
REQ-024 PC and addresses wrap modulo 2^ADDR_WIDTH; PC bit 0 forced 0.
REQ-025 retire and pc_o valid in the cycle leaving EXEC (non-memory) or MEM (on ack).

Reset
REQ-026 n_reset low: state=FETCH, PC=RESET_PC, R0-R15=0, PR=0, MACL=0, T=0, IR=0x0009; all outputs 0 except imem_addr=RESET_PC.
REQ-027 Reset mid-transfer drops req immediately (asynchronous); partially completed load/store has no architectural effect.
REQ-028 First imem_req rises in the first cycle after n_reset deasserts.

Configuration
REQ-029 Macro SH_CORE_MUL_EN defined: MUL.L Rm,Rn (0000nnnnmmmm0111) sets MACL=low REG_WIDTH bits of Rn*Rm in one EXEC cycle; STS MACL,Rn (0000nnnn00011010) sets Rn=MACL.
REQ-030 SH_CORE_MUL_EN undefined: no multiplier or MACL storage; both opcodes follow REQ-023.

Verification
REQ-031 Zero-wait memory, program MOV #5,R1; MOV #-3,R2; ADD R2,R1; SLEEP -> R1=2, four retire pulses, halted=1 after 8 cycles.
REQ-032 Store R1=0xDEADBEEF via MOV.L R1,@R3 (R3=0x100), dmem_ack delayed 3 cycles -> dmem_req high exactly 4 cycles with addr 0x100, wdata 0xDEADBEEF, we=1.
REQ-033 CMP/EQ R1,R1 then BT +4 at PC=0x10 -> next fetch 0x1C; with T=0 -> next fetch 0x12.
REQ-034 stall pulsed 5 cycles during FETCH with ack high -> no IR capture, imem_req held, execution resumes unchanged.
REQ-035 n_reset asserted during MEM load -> dmem_req drops same cycle, target register keeps 0, fetch restarts at RESET_PC.
REQ-036 Opcode 0xFFFF -> illegal pulse, retire, PC+=2; MUL.L with R1=7,R2=6 then STS MACL,R3 -> R3=42 (macro defined) or two illegal pulses (undefined).
